issue_scheduler: RTL and testbench
==================================

# issue_scheduler

In-order issue stage between the decoder and the execution units of the RV32I core. It buffers decoded instructions in a small FIFO and tracks pending register writes in a scoreboard. It releases the head instruction to exactly one execution unit, selected by `alu_sel`, once its operands are hazard-free and the target unit is ready. Execution-unit writebacks clear the scoreboard entry by tag.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TAG_W`, 4: instruction tag width; matches the decoder `o_tag`.

Ports:
- `i_clk` in 1: clock; one clock domain.
- `i_rst` in 1: synchronous, active-high reset.
- `i_dec_valid` in 1: decoder presents an instruction.
- `o_dec_ready` out 1: FIFO can accept; drives the decoder `i_en`.
- `i_rs1`, `i_rs2`, `i_rd` in 5 each: register indices.
- `i_next_pc` in 32, `i_instr` in 32: pass-through payload.
- `i_instr_format` in 3, `i_instr_type` in 3, `i_alu_sel` in 3, `i_tag` in TAG_W: decoded fields.
- `i_unit_ready` in 6: one bit per unit, indexed by `alu_sel` encoding (ADDER, LOGICAL, SHIFTER, BRANCH, MEMORY, BYPASS).
- `o_issue_valid` out 6: one-hot issue request; at most one bit set.
- `o_issue_rs1`, `o_issue_rs2`, `o_issue_rd`, `o_issue_next_pc`, `o_issue_instr`, `o_issue_instr_type`, `o_issue_tag`: head-entry payload, same widths as the inputs.
- `i_wb_valid` in 1, `i_wb_rd` in 5, `i_wb_tag` in TAG_W: unit completion.
- `i_flush` in 1: discard all queued, unissued instructions.
- `o_sb_busy` out 32: scoreboard busy bits, for debug and perf.

## Operation
- Enqueue fires when `i_dec_valid & o_dec_ready`. `o_dec_ready = !full`. There is no pass-through when full, even if an issue happens in the same cycle.
- Operand usage by format:
  - R: rs1, rs2, rd
  - I: rs1, rd
  - S/B: rs1, rs2
  - U/J: rd
  - Unknown format is treated as R.
- Head hazard exists if any used source register is busy (RAW), or the used rd is busy (WAW). Register x0 is never busy and never set.
- `o_issue_valid[alu_sel]` = head valid & no hazard & !`i_flush`. This is combinational from registered state. The hazard term does not depend on `i_unit_ready`.
- Issue fires when `o_issue_valid[k] & i_unit_ready[k]`. On fire: pop the head; set `busy[rd]` and `owner_tag[rd]=tag` if rd is used and nonzero.
- Writeback: if `busy[wb_rd]` and `owner_tag[wb_rd]==wb_tag`, clear `busy[wb_rd]`; otherwise ignore. Stale tags are dropped.
- Same-cycle writeback and issue to the same rd: the issue set wins.
- Flush: empties the FIFO (pointers and count to 0) and suppresses issue and enqueue that cycle. The scoreboard is kept, because in-flight instructions still write back.
- An invalid or unrecognised `alu_sel` routes to the BYPASS bit.

## Timing
- Reset values: FIFO empty, scoreboard all 0, owner tags 0, `o_issue_valid=0`, payload outputs 0, `o_dec_ready=1` from the first cycle after reset. Reset mid-operation drops every entry and busy bit.
- Latency: an instruction enqueued in cycle N can issue in cycle N+1 at the earliest.
- A writeback in cycle N unblocks a dependent head in cycle N+1. There is no same-cycle bypass.
- Back-to-back independent instructions sustain 1 issue per cycle.
- Full FIFO with simultaneous pop: `o_dec_ready` stays 0 that cycle and rises the next cycle.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- The valid/ready handshake is held stable: once raised, `o_issue_valid` and the payload stay constant until fire or flush.

## Structure
- `pkg.v` holds:
  - `alu_sel` encodings (ADDER..BYPASS) and `NUM_UNITS=6`
  - format encodings (R/I/S/B/U/J_TYPE)
  - a new `` `ISSUE_PAYLOAD_W `` constant
- Sub-module `issue_fifo`: a parameterised synchronous FIFO with flush, holding the packed payload.
- The scoreboard and hazard logic stay in `issue_scheduler`.

## Test plan
- Reset, then ADD x3,x1,x2 (tag 1) with all units ready → `o_issue_valid=ADDER` one-hot in the cycle after enqueue; `o_sb_busy[3]=1`.
- ADD x3 then SUB x4,x3,x5 → SUB is held while `busy[3]`. Writeback rd=3 tag=1 in cycle N → SUB issues in N+1.
- Writeback rd=3 with a stale tag 7 while the owner is tag 1 → `busy[3]` remains 1 and the dependent instruction stays stalled.
- Fill 4 entries with MEMORY ops and `i_unit_ready[MEMORY]=0` → `o_dec_ready=0`. Release ready → pops 1/cycle, `o_dec_ready` returns 1 the cycle after the first pop.
- Flush with 3 queued entries and one busy register → FIFO empty next cycle, no issue that cycle, busy bit retained until its writeback.
- SW x0 (S-type, rd field 5) followed by ADDI x5 → SW sets no busy bit; ADDI writing x0 never sets busy; no false WAW.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared encodings and payload constants for the issue stage
package issue_scheduler_pkg;

    localparam int NUM_UNITS = 6;

    // Tag-less payload: fmt(3) + alu_sel(3) + type(3) + instr(32) + next_pc(32) + rd/rs2/rs1(15)
    localparam int ISSUE_PAYLOAD_W = 88;

    typedef enum logic [2:0] {
        ADDER   = 3'd0,
        LOGICAL = 3'd1,
        SHIFTER = 3'd2,
        BRANCH  = 3'd3,
        MEMORY  = 3'd4,
        BYPASS  = 3'd5
    } alu_sel_e;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instr_format_e;

    // Unrecognised selector codes fall through to the bypass unit
    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [2:0] sel);
        logic [NUM_UNITS-1:0] r;
        if (sel <= BYPASS) begin
            r = NUM_UNITS'(1) << sel;
        end else begin
            r = NUM_UNITS'(1) << BYPASS;
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_scheduler_fifo.sv
// rtl/issue_scheduler_fifo.sv - synchronous payload FIFO with flush
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic         in_tready,
    output logic [W-1:0] out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Ready depends only on the registered count, so a pop never frees a slot in the same cycle
    always_comb begin
        in_tready  = (count_q != CW'(DEPTH));
        out_tvalid = (count_q != '0);
        out_tdata  = out_tvalid ? mem_q[rd_ptr_q] : '0;
        push       = in_tvalid & in_tready & ~flush;
        pop        = out_tvalid & out_tready & ~flush;
    end

    // Next-state for storage, pointers and occupancy; flush clears everything but the data array
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_tdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - in-order issue stage with register scoreboard
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dec_valid,
    output logic             o_dec_ready,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [4:0]       i_rd,
    input  logic [31:0]      i_next_pc,
    input  logic [31:0]      i_instr,
    input  logic [2:0]       i_instr_format,
    input  logic [2:0]       i_instr_type,
    input  logic [2:0]       i_alu_sel,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [5:0]       i_unit_ready,
    output logic [5:0]       o_issue_valid,
    output logic [4:0]       o_issue_rs1,
    output logic [4:0]       o_issue_rs2,
    output logic [4:0]       o_issue_rd,
    output logic [31:0]      o_issue_next_pc,
    output logic [31:0]      o_issue_instr,
    output logic [2:0]       o_issue_instr_type,
    output logic [TAG_W-1:0] o_issue_tag,
    input  logic             i_wb_valid,
    input  logic [4:0]       i_wb_rd,
    input  logic [TAG_W-1:0] i_wb_tag,
    input  logic             i_flush,
    output logic [31:0]      o_sb_busy
);
    localparam int PW = ISSUE_PAYLOAD_W + TAG_W;

    logic [PW-1:0]    enq_data;
    logic [PW-1:0]    head_data;
    logic             head_valid;
    logic             fire;
    logic [2:0]       h_fmt;
    logic [2:0]       h_sel;
    logic             use_rs1, use_rs2, use_rd;
    logic             hazard;

    logic [31:0]      busy_q, busy_d;
    logic [TAG_W-1:0] owner_q [32];
    logic [TAG_W-1:0] owner_d [32];

    assign enq_data = {i_instr_format, i_alu_sel, i_instr_type, i_instr, i_next_pc,
                       i_rd, i_rs2, i_rs1, i_tag};

    issue_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .flush      (i_flush),
        .in_tdata   (enq_data),
        .in_tvalid  (i_dec_valid),
        .in_tready  (o_dec_ready),
        .out_tdata  (head_data),
        .out_tvalid (head_valid),
        .out_tready (fire)
    );

    // Decode the head entry, work out which registers it touches, and raise the one-hot request
    always_comb begin
        {h_fmt, h_sel, o_issue_instr_type, o_issue_instr, o_issue_next_pc,
         o_issue_rd, o_issue_rs2, o_issue_rs1, o_issue_tag} = head_data;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        case (h_fmt)
            I_TYPE:         use_rs2 = 1'b0;
            S_TYPE, B_TYPE: use_rd  = 1'b0;
            U_TYPE, J_TYPE: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
            default:        ;
        endcase
        hazard = (use_rs1 & busy_q[o_issue_rs1]) |
                 (use_rs2 & busy_q[o_issue_rs2]) |
                 (use_rd  & busy_q[o_issue_rd]);
        o_issue_valid = (head_valid & ~hazard & ~i_flush) ? unit_onehot(h_sel) : '0;
        fire          = |(o_issue_valid & i_unit_ready);
        o_sb_busy     = busy_q;
    end

    // Scoreboard update: tag-matched writeback clears, an issue to the same rd overrides it
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (i_wb_valid && busy_q[i_wb_rd] && (owner_q[i_wb_rd] == i_wb_tag)) begin
            busy_d[i_wb_rd] = 1'b0;
        end
        if (fire && use_rd && (o_issue_rd != 5'd0)) begin
            busy_d[o_issue_rd]  = 1'b1;
            owner_d[o_issue_rd] = o_issue_tag;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard registers survive flush since in-flight work still writes back
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q  <= '0;
            owner_q <= '{default: '0};
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - directed self-checking bench for issue_scheduler
module tb_issue_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dec_valid;
    logic        o_dec_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [31:0] i_next_pc, i_instr;
    logic [2:0]  i_instr_format, i_instr_type, i_alu_sel;
    logic [3:0]  i_tag;
    logic [5:0]  i_unit_ready;
    logic [5:0]  o_issue_valid;
    logic [4:0]  o_issue_rs1, o_issue_rs2, o_issue_rd;
    logic [31:0] o_issue_next_pc, o_issue_instr;
    logic [2:0]  o_issue_instr_type;
    logic [3:0]  o_issue_tag;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [3:0]  i_wb_tag;
    logic        i_flush;
    logic [31:0] o_sb_busy;

    int passes = 0;
    int total  = 0;

    always #5 i_clk = ~i_clk;

    issue_scheduler #(.DEPTH(4), .TAG_W(4)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_dec_valid        (i_dec_valid),
        .o_dec_ready        (o_dec_ready),
        .i_rs1              (i_rs1),
        .i_rs2              (i_rs2),
        .i_rd               (i_rd),
        .i_next_pc          (i_next_pc),
        .i_instr            (i_instr),
        .i_instr_format     (i_instr_format),
        .i_instr_type       (i_instr_type),
        .i_alu_sel          (i_alu_sel),
        .i_tag              (i_tag),
        .i_unit_ready       (i_unit_ready),
        .o_issue_valid      (o_issue_valid),
        .o_issue_rs1        (o_issue_rs1),
        .o_issue_rs2        (o_issue_rs2),
        .o_issue_rd         (o_issue_rd),
        .o_issue_next_pc    (o_issue_next_pc),
        .o_issue_instr      (o_issue_instr),
        .o_issue_instr_type (o_issue_instr_type),
        .o_issue_tag        (o_issue_tag),
        .i_wb_valid         (i_wb_valid),
        .i_wb_rd            (i_wb_rd),
        .i_wb_tag           (i_wb_tag),
        .i_flush            (i_flush),
        .o_sb_busy          (o_sb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // fmt: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; sel: 0 ADDER .. 4 MEMORY, 5 BYPASS
    task automatic dec(input logic v, input logic [2:0] fmt, input logic [2:0] sel,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] tag);
        i_dec_valid    = v;
        i_instr_format = fmt;
        i_instr_type   = fmt;
        i_alu_sel      = sel;
        i_rs1          = rs1;
        i_rs2          = rs2;
        i_rd           = rd;
        i_tag          = tag;
        i_instr        = 32'hC0DE_0000 | {28'd0, tag};
        i_next_pc      = 32'h0000_1000 + {26'd0, tag, 2'b00};
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [3:0] tag);
        i_wb_valid = v;
        i_wb_rd    = rd;
        i_wb_tag   = tag;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_flush      = 1'b0;
        i_unit_ready = 6'h3F;
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        wb(1'b0, 5'd0, 4'd0);
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_valid", 64'(o_issue_valid), 64'h0);
        chk("rst_busy", 64'(o_sb_busy), 64'h0);
        chk("rst_ready", 64'(o_dec_ready), 64'h1);
        chk("rst_instr", 64'(o_issue_instr), 64'h0);
        chk("rst_tag", 64'(o_issue_tag), 64'h0);

        // ADD x3,x1,x2 tag 1
        dec(1'b1, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 4'd1);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("add_valid", 64'(o_issue_valid), 64'h01);
        chk("add_rd", 64'(o_issue_rd), 64'd3);
        chk("add_tag", 64'(o_issue_tag), 64'd1);
        chk("add_instr", 64'(o_issue_instr), 64'hC0DE0001);
        chk("add_pc", 64'(o_issue_next_pc), 64'h1004);
        tick();
        chk("add_busy", 64'(o_sb_busy), 64'h8);
        chk("add_popped", 64'(o_issue_valid), 64'h0);

        // SUB x4,x3,x5 tag 2 waits on x3
        dec(1'b1, 3'd0, 3'd0, 5'd3, 5'd5, 5'd4, 4'd2);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("raw_stall", 64'(o_issue_valid), 64'h0);
        wb(1'b1, 5'd3, 4'd7);
        tick();
        wb(1'b0, 5'd0, 4'd0);
        #1;
        chk("stale_busy", 64'(o_sb_busy), 64'h8);
        chk("stale_stall", 64'(o_issue_valid), 64'h0);
        wb(1'b1, 5'd3, 4'd1);
        #1;
        chk("wb_no_bypass", 64'(o_issue_valid), 64'h0);
        tick();
        wb(1'b0, 5'd0, 4'd0);
        #1;
        chk("sub_valid", 64'(o_issue_valid), 64'h01);
        chk("sub_tag", 64'(o_issue_tag), 64'd2);
        tick();
        chk("sub_busy", 64'(o_sb_busy), 64'h10);
        wb(1'b1, 5'd4, 4'd2);
        tick();
        wb(1'b0, 5'd0, 4'd0);
        #1;
        chk("sub_wb_busy", 64'(o_sb_busy), 64'h0);

        // Fill with MEMORY loads while MEMORY unit is stalled
        i_unit_ready = 6'b101111;
        dec(1'b1, 3'd1, 3'd4, 5'd0, 5'd0, 5'd6, 4'd3);
        tick();
        dec(1'b1, 3'd1, 3'd4, 5'd0, 5'd0, 5'd7, 4'd4);
        tick();
        dec(1'b1, 3'd1, 3'd4, 5'd0, 5'd0, 5'd8, 4'd5);
        tick();
        dec(1'b1, 3'd1, 3'd4, 5'd0, 5'd0, 5'd9, 4'd6);
        tick();
        dec(1'b1, 3'd1, 3'd4, 5'd0, 5'd0, 5'd10, 4'd7);
        #1;
        chk("full_ready", 64'(o_dec_ready), 64'h0);
        chk("full_valid", 64'(o_issue_valid), 64'h10);
        chk("full_rd", 64'(o_issue_rd), 64'd6);
        tick();
        chk("full_hold_ready", 64'(o_dec_ready), 64'h0);
        chk("full_hold_rd", 64'(o_issue_rd), 64'd6);
        i_unit_ready = 6'h3F;
        #1;
        chk("full_pop_ready", 64'(o_dec_ready), 64'h0);
        tick();
        chk("after_pop_ready", 64'(o_dec_ready), 64'h1);
        chk("after_pop_rd", 64'(o_issue_rd), 64'd7);
        chk("after_pop_busy", 64'(o_sb_busy), 64'h40);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("drain_rd8", 64'(o_issue_rd), 64'd8);
        tick();
        chk("drain_rd9", 64'(o_issue_rd), 64'd9);
        tick();
        chk("drain_tag7", 64'(o_issue_tag), 64'd7);
        chk("drain_rd10", 64'(o_issue_rd), 64'd10);
        tick();
        chk("drain_empty", 64'(o_issue_valid), 64'h0);
        chk("drain_busy", 64'(o_sb_busy), 64'h7C0);

        // Reset mid-operation clears busy bits
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(o_sb_busy), 64'h0);
        chk("mid_rst_ready", 64'(o_dec_ready), 64'h1);

        // Flush with three LOGICAL ops queued and x12 busy
        i_unit_ready = 6'b111101;
        dec(1'b1, 3'd0, 3'd0, 5'd1, 5'd2, 5'd12, 4'd8);
        tick();
        dec(1'b1, 3'd1, 3'd1, 5'd1, 5'd0, 5'd13, 4'd9);
        tick();
        dec(1'b1, 3'd1, 3'd1, 5'd1, 5'd0, 5'd14, 4'd10);
        tick();
        dec(1'b1, 3'd1, 3'd1, 5'd1, 5'd0, 5'd15, 4'd11);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("pre_flush_valid", 64'(o_issue_valid), 64'h02);
        chk("pre_flush_busy", 64'(o_sb_busy), 64'h1000);
        i_flush = 1'b1;
        dec(1'b1, 3'd1, 3'd0, 5'd1, 5'd0, 5'd16, 4'd15);
        #1;
        chk("flush_no_issue", 64'(o_issue_valid), 64'h0);
        tick();
        i_flush = 1'b0;
        i_unit_ready = 6'h3F;
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("flush_empty", 64'(o_issue_valid), 64'h0);
        chk("flush_tag", 64'(o_issue_tag), 64'h0);
        chk("flush_busy_kept", 64'(o_sb_busy), 64'h1000);
        wb(1'b1, 5'd12, 4'd8);
        tick();
        wb(1'b0, 5'd0, 4'd0);
        #1;
        chk("flush_wb_busy", 64'(o_sb_busy), 64'h0);

        // SW (rd field 5), ADDI x5, ADDI x0
        dec(1'b1, 3'd2, 3'd4, 5'd1, 5'd0, 5'd5, 4'd12);
        tick();
        dec(1'b1, 3'd1, 3'd0, 5'd1, 5'd0, 5'd5, 4'd13);
        #1;
        chk("sw_valid", 64'(o_issue_valid), 64'h10);
        tick();
        dec(1'b1, 3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 4'd14);
        #1;
        chk("sw_no_busy", 64'(o_sb_busy), 64'h0);
        chk("addi5_no_waw", 64'(o_issue_valid), 64'h01);
        chk("addi5_rd", 64'(o_issue_rd), 64'd5);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("addi5_busy", 64'(o_sb_busy), 64'h20);
        chk("addi0_valid", 64'(o_issue_valid), 64'h01);
        tick();
        chk("addi0_no_busy", 64'(o_sb_busy), 64'h20);
        chk("addi0_popped", 64'(o_issue_valid), 64'h0);

        // Unknown format behaves as R (rs2=x5 busy); unknown sel goes to BYPASS
        dec(1'b1, 3'd7, 3'd7, 5'd0, 5'd5, 5'd0, 4'd15);
        tick();
        dec(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #1;
        chk("unk_fmt_stall", 64'(o_issue_valid), 64'h0);
        wb(1'b1, 5'd5, 4'd13);
        tick();
        wb(1'b0, 5'd0, 4'd0);
        #1;
        chk("unk_sel_bypass", 64'(o_issue_valid), 64'h20);
        chk("unk_busy_clr", 64'(o_sb_busy), 64'h0);
        tick();
        chk("final_empty", 64'(o_issue_valid), 64'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
